// File: rtl/host_sig_dumper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : host_sig_dumper_pkg
// Description : Mailbox map, DCatch window constants and dumper FSM states.
// Revision    : 1.0
// ============================================================================
package host_sig_dumper_pkg;

    localparam logic [31:0] c_HOST_BASE         = 32'h1000_0000;
    localparam logic [31:0] c_HOST_BEGIN_OFF    = 32'h0000_0008;
    localparam logic [31:0] c_HOST_END_OFF      = 32'h0000_000C;
    localparam logic [31:0] c_HOST_FLAG_OFF     = 32'h0000_0010;
    localparam logic [31:0] c_HOST_STAT_OFF     = 32'h0000_0014;
    localparam logic [31:0] c_DCATCH_START_ADDR = 32'h0000_1000;
    localparam int          c_DMEM_AW           = 11;
    // One extra index bit so an END sitting exactly past the last word fits.
    localparam int          c_IDX_W             = c_DMEM_AW + 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_LOAD = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/host_sig_dumper_if.sv
`default_nettype none
// ============================================================================
// Module      : host_sig_dumper_if
// Description : Core store bus, DCatch read port and signature stream bundle.
// Revision    : 1.0
// ============================================================================
interface host_sig_dumper_if;
    import host_sig_dumper_pkg::*;

    logic                 bus_we;
    logic [31:0]          bus_addr;
    logic [31:0]          bus_wdata;
    logic [31:0]          bus_rdata;
    logic                 mem_re;
    logic [c_DMEM_AW-1:0] mem_raddr;
    logic [31:0]          mem_rdata;
    logic                 core_halt;
    logic                 out_valid;
    logic                 out_ready;
    logic [31:0]          out_data;
    logic                 out_last;
    logic                 done;
    logic                 err;

    modport master (
        output bus_we, bus_addr, bus_wdata, mem_rdata, out_ready,
        input  bus_rdata, mem_re, mem_raddr, core_halt,
               out_valid, out_data, out_last, done, err
    );

    modport slave (
        input  bus_we, bus_addr, bus_wdata, mem_rdata, out_ready,
        output bus_rdata, mem_re, mem_raddr, core_halt,
               out_valid, out_data, out_last, done, err
    );

endinterface
`default_nettype wire

// File: rtl/host_sig_dumper.sv
`default_nettype none
// ============================================================================
// Module      : host_sig_dumper
// Description : Host mailbox that halts the core and streams the DCatch
//               signature window out on a valid/ready port.
// Revision    : 1.0
// ============================================================================
module host_sig_dumper
    import host_sig_dumper_pkg::*;
#(
    parameter logic [31:0] HOST_BASE = c_HOST_BASE,
    parameter logic [31:0] DMEM_BASE = c_DCATCH_START_ADDR
) (
    input  logic             clk,
    input  logic             rst,
    host_sig_dumper_if.slave bus
);

    localparam logic [32:0]         c_LIMIT   = {1'b0, DMEM_BASE} + (33'd4 << c_DMEM_AW);
    localparam logic [c_IDX_W-1:0]  c_IDX_ONE = c_IDX_W'(1);

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_begin;
    logic [31:0]        r_end;
    logic [31:0]        r_flag;
    logic [31:0]        r_out_data;
    logic [c_IDX_W-1:0] r_idx;
    logic [c_IDX_W-1:0] r_eidx;
    logic [c_IDX_W-1:0] w_bidx;
    logic [c_IDX_W-1:0] w_eidx;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_err;
    logic               w_idle;
    logic               w_wr_begin;
    logic               w_wr_end;
    logic               w_wr_flag;
    logic               w_trig;
    logic               w_win_err;
    logic               w_win_empty;
    logic               w_xfer;
    logic               w_busy;
    logic [31:0]        w_status;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a < DMEM_BASE) || ({1'b0, a} > c_LIMIT);
    endfunction

    assign w_idle      = (r_state == S_IDLE);
    assign w_wr_begin  = w_idle && bus.bus_we && (bus.bus_addr == HOST_BASE + c_HOST_BEGIN_OFF);
    assign w_wr_end    = w_idle && bus.bus_we && (bus.bus_addr == HOST_BASE + c_HOST_END_OFF);
    assign w_wr_flag   = w_idle && bus.bus_we && (bus.bus_addr == HOST_BASE + c_HOST_FLAG_OFF);
    assign w_trig      = w_wr_flag && bus.bus_wdata[0];
    assign w_bidx      = c_IDX_W'((r_begin - DMEM_BASE) >> 2);
    assign w_eidx      = c_IDX_W'((r_end - DMEM_BASE) >> 2);
    assign w_win_err   = addr_bad(r_begin) || addr_bad(r_end) || (r_end < r_begin);
    assign w_win_empty = (r_end == r_begin);
    assign w_xfer      = (r_state == S_SEND) && r_out_valid && bus.out_ready;
    assign w_busy      = (r_state == S_READ) || (r_state == S_LOAD) || (r_state == S_SEND);
    assign w_status    = {29'b0, r_err, (r_state == S_DONE), w_busy};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_trig) w_next = (w_win_err || w_win_empty) ? S_DONE : S_READ;
            S_READ:  w_next = S_LOAD;
            S_LOAD:  w_next = S_SEND;
            S_SEND:  if (w_xfer) w_next = r_out_last ? S_DONE : S_READ;
            S_DONE:  w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_begin     <= '0;
            r_end       <= '0;
            r_flag      <= '0;
            r_idx       <= '0;
            r_eidx      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_wr_begin) r_begin <= bus.bus_wdata;
            if (w_wr_end)   r_end   <= bus.bus_wdata;
            if (w_wr_flag)  r_flag  <= bus.bus_wdata;
            if (w_trig) begin
                r_err <= w_win_err;
                if (!w_win_err && !w_win_empty) begin
                    r_idx  <= w_bidx;
                    r_eidx <= w_eidx;
                end
            end
            // DCatch data arrives one cycle after the READ-state request.
            if (r_state == S_LOAD) begin
                r_out_data  <= bus.mem_rdata;
                r_out_valid <= 1'b1;
                r_out_last  <= (r_idx == r_eidx - c_IDX_ONE);
            end
            if (w_xfer) begin
                r_out_valid <= 1'b0;
                if (!r_out_last) r_idx <= r_idx + c_IDX_ONE;
            end
        end
    end

    always_comb begin
        bus.bus_rdata = 32'h0;
        if (bus.bus_addr == HOST_BASE + c_HOST_BEGIN_OFF)     bus.bus_rdata = r_begin;
        else if (bus.bus_addr == HOST_BASE + c_HOST_END_OFF)  bus.bus_rdata = r_end;
        else if (bus.bus_addr == HOST_BASE + c_HOST_FLAG_OFF) bus.bus_rdata = r_flag;
        else if (bus.bus_addr == HOST_BASE + c_HOST_STAT_OFF) bus.bus_rdata = w_status;
    end

    assign bus.mem_re    = (r_state == S_READ);
    assign bus.mem_raddr = r_idx[c_DMEM_AW-1:0];
    assign bus.core_halt = !w_idle;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.done      = (r_state == S_DONE);
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_host_sig_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_host_sig_dumper
// Description : Scoreboard bench for the signature dumper with a DCatch model.
// Revision    : 1.0
// ============================================================================
module tb_host_sig_dumper;

    localparam logic [31:0] HB     = 32'h1000_0000;
    localparam logic [31:0] A_BEG  = HB + 32'h08;
    localparam logic [31:0] A_END  = HB + 32'h0C;
    localparam logic [31:0] A_FLAG = HB + 32'h10;
    localparam logic [31:0] A_STAT = HB + 32'h14;
    localparam logic [31:0] A_BAD  = HB + 32'h20;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        toggle_en = 1'b0;
    logic [31:0] mem [0:2047];
    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_xfer = 0;

    host_sig_dumper_if bus_if();

    host_sig_dumper dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // DCatch synchronous read port.
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = mem_val(i);
        bus_if.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (bus_if.mem_re) bus_if.mem_rdata <= mem[bus_if.mem_raddr];
        end
    end

    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus_if.out_ready = toggle_en ? ~bus_if.out_ready : 1'b1;
        end
    end

    // Monitor: pops expected words on each transfer and checks stall stability.
    initial begin
        logic        stalled;
        logic [31:0] hd;
        logic        hl;
        exp_t        e;
        stalled = 1'b0;
        hd = '0;
        hl = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.out_valid) begin
                if (stalled) begin
                    chk("stall_data", bus_if.out_data, hd);
                    chk("stall_last", {31'b0, bus_if.out_last}, {31'b0, hl});
                end
                if (bus_if.out_ready) begin
                    stalled = 1'b0;
                    n_xfer++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_word: got %h expected no word", bus_if.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("word_data", bus_if.out_data, e.data);
                        chk("word_last", {31'b0, bus_if.out_last}, {31'b0, e.last});
                    end
                end else begin
                    stalled = 1'b1;
                    hd = bus_if.out_data;
                    hl = bus_if.out_last;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus_if.bus_we    = 1'b1;
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        @(posedge clk);
        #1;
        bus_if.bus_we = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus_if.bus_addr = a;
        #1;
        chk(name, bus_if.bus_rdata, exp);
    endtask

    task automatic push_window(input int first, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.data = mem_val(first + k);
            e.last = (k == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !bus_if.done; i++) begin
            @(posedge clk);
            #1;
        end
        chk("done_timeout", {31'b0, bus_if.done}, 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_halt"},  {31'b0, bus_if.core_halt}, 32'd0);
        chk({tag, "_valid"}, {31'b0, bus_if.out_valid}, 32'd0);
        chk({tag, "_data"},  bus_if.out_data, 32'd0);
        chk({tag, "_last"},  {31'b0, bus_if.out_last}, 32'd0);
        chk({tag, "_done"},  {31'b0, bus_if.done}, 32'd0);
        chk({tag, "_err"},   {31'b0, bus_if.err}, 32'd0);
        chk({tag, "_re"},    {31'b0, bus_if.mem_re}, 32'd0);
        chk({tag, "_raddr"}, {21'b0, bus_if.mem_raddr}, 32'd0);
        read_chk({tag, "_status"}, A_STAT, 32'd0);
    endtask

    logic [31:0] err_b [3];
    logic [31:0] err_e [3];

    initial begin
        int base;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_addr  = 32'h0;
        bus_if.bus_wdata = 32'h0;
        err_b[0] = 32'h2002; err_e[0] = 32'h2090;
        err_b[1] = 32'h2090; err_e[1] = 32'h2000;
        err_b[2] = 32'h2000; err_e[2] = 32'h3004;

        // Reset state and mailbox readback / write-ignore behaviour.
        do_reset();
        check_idle_outputs("reset");
        read_chk("reset_begin", A_BEG, 32'h0);
        bus_write(A_BEG, 32'h2000);
        bus_write(A_END, 32'h2090);
        read_chk("rb_begin", A_BEG, 32'h2000);
        read_chk("rb_end", A_END, 32'h2090);
        bus_write(A_FLAG, 32'h0);
        bus_write(A_FLAG, 32'h2);
        repeat (4) @(posedge clk);
        #1;
        chk("flag0_halt", {31'b0, bus_if.core_halt}, 32'd0);
        chk("flag0_re", {31'b0, bus_if.mem_re}, 32'd0);
        read_chk("rb_flag", A_FLAG, 32'h2);
        bus_write(A_BAD, 32'hFFFF_FFFF);
        read_chk("rb_unmapped", A_BAD, 32'h0);
        read_chk("rb_begin_kept", A_BEG, 32'h2000);
        read_chk("rb_end_kept", A_END, 32'h2090);
        read_chk("rb_status_idle", A_STAT, 32'h0);

        // Full dump with out_ready held high, plus trigger latency.
        base = n_xfer;
        push_window(32'h400, 36);
        bus_write(A_FLAG, 32'h1);
        chk("trig_halt", {31'b0, bus_if.core_halt}, 32'd1);
        chk("trig_re", {31'b0, bus_if.mem_re}, 32'd1);
        chk("trig_raddr", {21'b0, bus_if.mem_raddr}, 32'h400);
        chk("trig_valid", {31'b0, bus_if.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("e1_valid", {31'b0, bus_if.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        chk("e2_valid", {31'b0, bus_if.out_valid}, 32'd1);
        read_chk("status_busy", A_STAT, 32'h1);
        bus_write(A_BEG, 32'h2500);
        read_chk("begin_locked", A_BEG, 32'h2000);
        wait_done(400);
        chk("full_err", {31'b0, bus_if.err}, 32'd0);
        chk("full_halt", {31'b0, bus_if.core_halt}, 32'd1);
        chk("full_count", 32'(n_xfer - base), 32'd36);
        chk("full_q_empty", 32'(exp_q.size()), 32'd0);
        read_chk("status_done", A_STAT, 32'h2);

        // Same window with out_ready toggling every cycle.
        do_reset();
        toggle_en = 1'b1;
        base = n_xfer;
        bus_write(A_BEG, 32'h2000);
        bus_write(A_END, 32'h2090);
        push_window(32'h400, 36);
        bus_write(A_FLAG, 32'h1);
        wait_done(800);
        toggle_en = 1'b0;
        chk("tog_count", 32'(n_xfer - base), 32'd36);
        chk("tog_q_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset after five words, then a clean restart.
        do_reset();
        base = n_xfer;
        bus_write(A_BEG, 32'h2000);
        bus_write(A_END, 32'h2090);
        push_window(32'h400, 36);
        bus_write(A_FLAG, 32'h1);
        for (int i = 0; i < 200 && (n_xfer - base) < 5; i++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_count", 32'(n_xfer - base), 32'd5);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_idle_outputs("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b1;
        read_chk("rst_begin_clr", A_BEG, 32'h0);
        base = n_xfer;
        bus_write(A_BEG, 32'h2000);
        bus_write(A_END, 32'h2090);
        push_window(32'h400, 36);
        bus_write(A_FLAG, 32'h1);
        wait_done(400);
        chk("restart_count", 32'(n_xfer - base), 32'd36);
        chk("restart_q_empty", 32'(exp_q.size()), 32'd0);

        // Invalid windows finish one edge after the trigger with err set.
        for (int t = 0; t < 3; t++) begin
            do_reset();
            base = n_xfer;
            bus_write(A_BEG, err_b[t]);
            bus_write(A_END, err_e[t]);
            bus_write(A_FLAG, 32'h1);
            chk($sformatf("err%0d_done", t), {31'b0, bus_if.done}, 32'd1);
            chk($sformatf("err%0d_err", t), {31'b0, bus_if.err}, 32'd1);
            chk($sformatf("err%0d_halt", t), {31'b0, bus_if.core_halt}, 32'd1);
            repeat (5) @(posedge clk);
            #1;
            chk($sformatf("err%0d_words", t), 32'(n_xfer - base), 32'd0);
            read_chk($sformatf("err%0d_status", t), A_STAT, 32'h6);
        end

        // Empty window.
        do_reset();
        base = n_xfer;
        bus_write(A_BEG, 32'h2000);
        bus_write(A_END, 32'h2000);
        bus_write(A_FLAG, 32'h1);
        chk("empty_done", {31'b0, bus_if.done}, 32'd1);
        chk("empty_err", {31'b0, bus_if.err}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("empty_words", 32'(n_xfer - base), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
